// File: rtl/mopshub_link_pkg.sv
// Shared types and constants for the MOPSHUB serial message link.
package mopshub_link_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hAA;
    localparam int unsigned MSG_W     = 76;
    localparam int unsigned CANID_W   = 12;
    localparam int unsigned PAYLOAD_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    typedef struct packed {
        logic [CANID_W-1:0]   can_id;
        logic [PAYLOAD_W-1:0] payload;
    } msg_t;

endpackage

// File: rtl/uplink_frame_deserializer_frame_out_reg.sv
// Single-entry valid/ready holding register; flags a load that arrives while full and not draining.
module frame_out_reg
    import mopshub_link_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [MSG_W-1:0] load_data,
    input  logic             ready,
    output logic [MSG_W-1:0] data,
    output logic             valid,
    output logic             overflow_c
);

    msg_t held;

    assign overflow_c = load && valid && !ready;
    assign data       = held;

    // A load in the same cycle as a consume replaces the entry and keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held  <= '0;
            valid <= 1'b0;
        end else if (load && !overflow_c) begin
            held  <= msg_t'(load_data);
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uplink_frame_deserializer.sv
// Reassembles SYNC-framed byte stream into 76-bit messages with XOR checksum,
// pad check and inter-byte timeout; good messages go out over valid/ready.
module uplink_frame_deserializer
    import mopshub_link_pkg::*;
#(
    parameter logic [7:0]  SYNC           = SYNC_BYTE,
    parameter int unsigned N_DATA_BYTES   = 10,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    output logic [MSG_W-1:0] frame_data,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             chk_err,
    output logic             timeout_err,
    output logic             overflow_err,
    output logic [CNT_W-1:0] frame_count,
    output logic             busy
);

    localparam int unsigned SHIFT_W = N_DATA_BYTES * 8;
    localparam int unsigned CNT_BW  = $clog2(N_DATA_BYTES);
    localparam int unsigned GAP_W   = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state, state_nx;
    logic [SHIFT_W-1:0]   shift_q;
    logic [7:0]           xor_q;
    logic [CNT_BW-1:0]    byte_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 gap_hit_c, chk_ok_c, load_c, bad_c, ovf_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next state and per-cycle frame strobes.
    always_comb begin
        state_nx  = state;
        load_c    = 1'b0;
        bad_c     = 1'b0;
        gap_hit_c = (state != ST_IDLE) && !rx_valid &&
                    (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1));
        chk_ok_c  = (rx_byte == xor_q) && (shift_q[SHIFT_W-1:MSG_W] == '0);
        case (state)
            ST_IDLE: begin
                if (rx_valid && rx_byte == SYNC) state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (gap_hit_c)
                    state_nx = ST_IDLE;
                else if (rx_valid && byte_cnt == CNT_BW'(N_DATA_BYTES - 1))
                    state_nx = ST_CHECK;
            end
            ST_CHECK: begin
                if (gap_hit_c) begin
                    state_nx = ST_IDLE;
                end else if (rx_valid) begin
                    state_nx = ST_IDLE;
                    load_c   = chk_ok_c;
                    bad_c    = !chk_ok_c;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    frame_out_reg u_out (
        .clk        (clk),
        .rst        (rst),
        .load       (load_c),
        .load_data  (shift_q[MSG_W-1:0]),
        .ready      (frame_ready),
        .data       (frame_data),
        .valid      (frame_valid),
        .overflow_c (ovf_c)
    );

    // Shifter, checksum, byte/gap counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q      <= '0;
            xor_q        <= '0;
            byte_cnt     <= '0;
            gap_cnt      <= '0;
            chk_err      <= 1'b0;
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
            frame_count  <= '0;
            busy         <= 1'b0;
        end else begin
            chk_err      <= bad_c;
            timeout_err  <= gap_hit_c;
            overflow_err <= ovf_c;
            busy         <= (state_nx != ST_IDLE);
            if (load_c && !ovf_c) frame_count <= frame_count + CNT_W'(1);
            case (state)
                ST_IDLE: begin
                    if (rx_valid && rx_byte == SYNC) begin
                        byte_cnt <= '0;
                        xor_q    <= '0;
                        gap_cnt  <= '0;
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        shift_q  <= {shift_q[SHIFT_W-9:0], rx_byte};
                        xor_q    <= xor_q ^ rx_byte;
                        byte_cnt <= byte_cnt + CNT_BW'(1);
                        gap_cnt  <= '0;
                    end else begin
                        gap_cnt  <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (rx_valid) gap_cnt <= '0;
                    else          gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: gap_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uplink_frame_deserializer.sv
// Scoreboard bench for uplink_frame_deserializer; a 4-bit-counter twin checks frame_count wrap.
module tb_uplink_frame_deserializer;
    import mopshub_link_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [75:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        chk_err, timeout_err, overflow_err, busy;
    logic [15:0] frame_count;

    logic [75:0] s_data;
    logic        s_valid, s_chk, s_to, s_ovf, s_busy;
    logic [3:0]  s_count;
    logic        s_ready;

    int checks   = 0;
    int failures = 0;
    int n_chk = 0, n_to = 0, n_ovf = 0;
    logic [75:0] sb_q[$];
    logic [15:0] exp_count;
    logic [3:0]  exp_small;

    always #5 clk = ~clk;

    uplink_frame_deserializer dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .chk_err(chk_err), .timeout_err(timeout_err), .overflow_err(overflow_err),
        .frame_count(frame_count), .busy(busy)
    );

    uplink_frame_deserializer #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .frame_data(s_data), .frame_valid(s_valid), .frame_ready(s_ready),
        .chk_err(s_chk), .timeout_err(s_to), .overflow_err(s_ovf),
        .frame_count(s_count), .busy(s_busy)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: error pulse tally and scoreboard pop on every transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_err)      n_chk++;
            if (timeout_err)  n_to++;
            if (overflow_err) n_ovf++;
            if (chk_err || timeout_err || overflow_err)
                check("err_exclusive", 80'(int'(chk_err) + int'(timeout_err) + int'(overflow_err)), 80'd1);
            if (frame_valid && frame_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame actual=%h required=none", frame_data);
                end else begin
                    check("frame_data", 80'(frame_data), 80'(sb_q.pop_front()));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Sends SYNC + data bytes; the CHK byte is left to the caller.
    task automatic send_body(input logic [75:0] m, input logic [3:0] pad, output logic [7:0] x);
        logic [79:0] d;
        d = {pad, m};
        x = 8'h00;
        send_byte(8'hAA);
        for (int i = 0; i < 10; i++) begin
            send_byte(d[79-8*i -: 8]);
            x = x ^ d[79-8*i -: 8];
        end
    endtask

    task automatic send_msg(input logic [75:0] m, input logic [3:0] pad, input logic [7:0] flip);
        logic [7:0] x;
        send_body(m, pad, x);
        send_byte(x ^ flip);
    endtask

    task automatic good(input logic [75:0] m, input bit expect_out);
        if (expect_out) begin
            sb_q.push_back(m);
            exp_count = exp_count + 16'd1;
        end
        exp_small = exp_small + 4'd1;
        send_msg(m, 4'h0, 8'h00);
    endtask

    initial begin
        int c0;
        logic [7:0]  x;
        logic [75:0] ma, mb;
        rst = 1'b1; rx_byte = '0; rx_valid = 1'b0; frame_ready = 1'b1; s_ready = 1'b1;
        exp_count = '0; exp_small = '0;
        idle(3);
        check("rst_frame_valid", 80'(frame_valid), 80'd0);
        check("rst_frame_count", 80'(frame_count), 80'd0);
        check("rst_busy", 80'(busy), 80'd0);
        check("rst_errs", 80'({chk_err, timeout_err, overflow_err}), 80'd0);
        rst = 1'b0;
        idle(2);

        // 1: hand-built frame 01..0A, chk 0B
        sb_q.push_back(76'h1_0203_0405_0607_0809_0A);
        exp_count = 16'd1; exp_small = 4'd1;
        send_byte(8'hAA);
        for (int i = 1; i <= 10; i++) send_byte(8'(i));
        check("busy_in_frame", 80'(busy), 80'd1);
        check("valid_before_chk", 80'(frame_valid), 80'd0);
        send_byte(8'h0B);
        check("valid_latency", 80'(frame_valid), 80'd1);
        idle(3);
        check("t1_count", 80'(frame_count), 80'd1);
        check("t1_no_chk_err", 80'(n_chk), 80'd0);

        // 2: same frame, bad checksum
        c0 = n_chk;
        send_byte(8'hAA);
        for (int i = 1; i <= 10; i++) send_byte(8'(i));
        send_byte(8'h0C);
        idle(3);
        check("t2_chk_err", 80'(n_chk - c0), 80'd1);
        check("t2_count", 80'(frame_count), 80'd1);
        check("t2_no_valid", 80'(frame_valid), 80'd0);

        // nonzero pad with correct xor is also a check error
        c0 = n_chk;
        send_msg(76'h0_0000_0000_0000_0000_55, 4'h1, 8'h00);
        idle(3);
        check("pad_chk_err", 80'(n_chk - c0), 80'd1);
        check("pad_count", 80'(frame_count), 80'd1);

        // 3: timeout after SYNC + 4 bytes
        c0 = n_to;
        send_byte(8'hAA);
        for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i));
        idle(63);
        check("t3_no_early_timeout", 80'(n_to - c0), 80'd0);
        check("t3_busy_63", 80'(busy), 80'd1);
        idle(3);
        check("t3_timeout", 80'(n_to - c0), 80'd1);
        check("t3_busy_after", 80'(busy), 80'd0);
        good(76'hABC_1122_3344_5566_7788, 1'b1);
        idle(3);
        check("t3_recover_count", 80'(frame_count), 80'(exp_count));

        // 4: held output, second frame overflows
        frame_ready = 1'b0;
        c0 = n_ovf;
        ma = 76'h123_0000_1111_2222_3333;
        mb = 76'h456_4444_5555_6666_7777;
        good(ma, 1'b1);
        good(mb, 1'b0);
        idle(3);
        check("t4_overflow", 80'(n_ovf - c0), 80'd1);
        check("t4_count", 80'(frame_count), 80'(exp_count));
        check("t4_held_valid", 80'(frame_valid), 80'd1);
        check("t4_held_data", 80'(frame_data), 80'(ma));
        // consume in the same cycle the next frame loads: load wins, no overflow
        c0 = n_ovf;
        send_body(mb, 4'h0, x);
        frame_ready = 1'b1;
        sb_q.push_back(mb);
        exp_count = exp_count + 16'd1;
        exp_small = exp_small + 4'd1;
        send_byte(x);
        check("t4_load_wins_valid", 80'(frame_valid), 80'd1);
        idle(3);
        check("t4_no_overflow", 80'(n_ovf - c0), 80'd0);
        check("t4_drained", 80'(frame_valid), 80'd0);

        // 5: 100 back-to-back frames with SYNC-valued data bytes
        for (int i = 0; i < 100; i++)
            good({12'(12'hAA0 + 12'(i)), 64'hAAAA_55AA_0000_0000 | 64'(i)}, 1'b1);
        idle(3);
        check("t5_count", 80'(frame_count), 80'(exp_count));
        check("t5_sb_empty", 80'(sb_q.size()), 80'd0);
        check("t5_small_wrap", 80'(s_count), 80'(exp_small));

        // 6: reset in the middle of a frame, with an undrained frame held
        frame_ready = 1'b0;
        good(76'hFED_CBA9_8765_4321_0FED, 1'b1);
        send_byte(8'hAA);
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
        rx_byte = 8'h44; rx_valid = 1'b1; rst = 1'b1;
        #1;
        check("t6_rst_valid", 80'(frame_valid), 80'd0);
        check("t6_rst_count", 80'(frame_count), 80'd0);
        check("t6_rst_busy", 80'(busy), 80'd0);
        sb_q.delete();
        exp_count = '0; exp_small = '0;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; rst = 1'b0; frame_ready = 1'b1;
        idle(2);
        good(76'h0F0_A5A5_5A5A_C3C3_3C3C, 1'b1);
        idle(3);
        check("t6_after_count", 80'(frame_count), 80'd1);
        check("t6_small_count", 80'(s_count), 80'd1);
        check("final_sb_empty", 80'(sb_q.size()), 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
